// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The FIFO takes the slave modport; the producer/consumer side takes the master modport.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  W_inc;
  logic [DATA_WIDTH-1:0] W_Data;
  logic                  R_inc;
  logic [DATA_WIDTH-1:0] R_Data;
  logic                  Full;
  logic                  Empty;
  logic                  Almost_Full;
  logic                  Almost_Empty;
  logic [ADDR_WIDTH:0]   Level;
  logic                  Overflow;
  logic                  Underflow;
  logic                  Err_clr;

  modport master (
    output W_inc, W_Data, R_inc, Err_clr,
    input  R_Data, Full, Empty, Almost_Full, Almost_Empty, Level, Overflow, Underflow
  );

  modport slave (
    input  W_inc, W_Data, R_inc, Err_clr,
    output R_Data, Full, Empty, Almost_Full, Almost_Empty, Level, Overflow, Underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered fill level, threshold flags, sticky errors
// and a choice of registered (standard) or first-word-fall-through read data.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input logic                CLK,
  input logic                rst,
  sync_fifo_flags_if.slave   fifo_if
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  generate
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: AE_THRESH out of range 0..DEPTH-1");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0] FULL_LVL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL   = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL   = AE_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic full, empty, wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] waddr, raddr;

  // Flags decode only registered level, so requests never reach them combinationally.
  assign full   = (level_q == FULL_LVL);
  assign empty  = (level_q == '0);
  assign wr_acc = fifo_if.W_inc & ~full;
  assign rd_acc = fifo_if.R_inc & ~empty;
  assign waddr  = wptr_q[ADDR_WIDTH-1:0];
  assign raddr  = rptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (fifo_if.Err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (fifo_if.W_inc & full)  ovf_d = 1'b1;
    if (fifo_if.R_inc & empty) udf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[waddr] <= fifo_if.W_Data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      always_comb begin
        fifo_if.R_Data = '0;
        if (!empty) fifo_if.R_Data = mem[raddr];
      end
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge CLK or posedge rst) begin
        if (rst)         rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem[raddr];
      end
      assign fifo_if.R_Data = rdata_q;
    end
  endgenerate

  assign fifo_if.Full         = full;
  assign fifo_if.Empty        = empty;
  assign fifo_if.Almost_Full  = (level_q >= AF_LVL);
  assign fifo_if.Almost_Empty = (level_q <= AE_LVL);
  assign fifo_if.Level        = level_q;
  assign fifo_if.Overflow     = ovf_q;
  assign fifo_if.Underflow    = udf_q;

  // Registered level must always agree with the pointer distance.
  a_level_ptr: assert property (@(posedge CLK) disable iff (rst) level_q == (wptr_q - rptr_q));
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO: next generation of our FIFO family for blocks that do not cross clock domains.
- Adds features the dual-clock FIFO lacks:
  - exact fill level
  - programmable almost-full / almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - sticky overflow/underflow error flags with clear
- Storage, pointers and flag logic are all internal; no synchronisers.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
- AF_THRESH, 12, Almost_Full asserts when Level >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, Almost_Empty asserts when Level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- W_inc  in  1  write request.
- W_Data  in  DATA_WIDTH  write data.
- R_inc  in  1  read request (pop).
- R_Data  out  DATA_WIDTH  read data.
- Full  out  1  Level == DEPTH.
- Empty  out  1  Level == 0.
- Almost_Full  out  1  Level >= AF_THRESH.
- Almost_Empty  out  1  Level <= AE_THRESH.
- Level  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
- Overflow  out  1  sticky: write attempted while Full.
- Underflow  out  1  sticky: read attempted while Empty.
- Err_clr  in  1  synchronous clear of Overflow/Underflow.

Behaviour:
- Reset (rst=1, async, any time including mid-operation):
  - Pointers 0, Level=0, Empty=1, Almost_Empty=1.
  - Full=0, Almost_Full=0, Overflow=0, Underflow=0, R_Data=0.
  - Memory contents not reset. All stored data is discarded.
- Accept rules, evaluated on pre-edge state:
  - write accepted iff W_inc & ~Full
  - read accepted iff R_inc & ~Empty
- Pointers:
  - Write and read pointers are ADDR_WIDTH+1-bit binary; low ADDR_WIDTH bits address memory; natural wrap at 2**(ADDR_WIDTH+1).
  - Level is registered; next Level = Level + wr_acc - rd_acc.
- Simultaneous requests:
  - Both accepted: Level unchanged, both pointers advance.
  - Full with W_inc & R_inc: read accepted, write dropped, Overflow set; Level becomes DEPTH-1.
  - Empty with W_inc & R_inc: write accepted, read rejected, Underflow set; Level becomes 1.
- Status flags:
  - Full, Empty, Almost_Full, Almost_Empty are decoded from registered Level only (no combinational path from W_inc/R_inc).
  - They update in the same cycle Level updates.
- Sticky errors:
  - Overflow set on W_inc & Full; Underflow set on R_inc & Empty.
  - Err_clr=1 clears both at the edge.
  - Set condition and Err_clr in the same cycle: set wins.
- Standard mode (FWFT=0):
  - On accepted read, R_Data <= mem[rd_addr]; valid the cycle after the R_inc edge (latency 1).
  - R_Data holds its value when no read is accepted, including rejected reads.
- FWFT mode (FWFT=1):
  - R_Data = mem[rd_addr] combinationally whenever Empty=0; forced to 0 while Empty=1.
  - R_inc acknowledges/pops the presented word; the next word appears the cycle after the pop edge.
  - Write to an empty FIFO: Empty deasserts and data appears one cycle after the write edge.
- Write/read of the same address in one cycle cannot occur unless Level is 0 or DEPTH, and the accept rules exclude both cases.
- Parameter check: out-of-range AF_THRESH/AE_THRESH must trigger an elaboration-time error.

Test Plan:
1. Bench config for all scenarios: ADDR_WIDTH=2 (DEPTH 4), DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1, FWFT=0 unless stated.
2. Reset then idle:
   - Empty=1, Almost_Empty=1, Full=0, Almost_Full=0, Level=0, R_Data=0x00.
3. Write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles:
   - Level 1,2,3,4.
   - Almost_Empty drops after the 2nd write; Almost_Full rises after the 3rd; Full after the 4th.
   - A 5th write of 0xA5 is dropped, Overflow=1, Level stays 4.
4. From full, read 4 times:
   - R_Data = 0xA1..0xA4, each one cycle after its R_inc edge.
   - A 5th read sets Underflow=1 and R_Data holds 0xA4.
   - Err_clr clears both flags.
5. Wrap and simultaneous access:
   - Run 10 cycles of W_inc=R_inc=1 at Level=2 with incrementing data.
   - Level stays 2 throughout; data order preserved across pointer wrap.
   - Then, while Full, assert W_inc=R_inc=1: read accepted, write dropped, Level=3, Overflow=1.
6. FWFT=1:
   - Write 0x5C to an empty FIFO: next cycle Empty=0 and R_Data=0x5C with no R_inc.
   - Pulse R_inc: next cycle Empty=1 and R_Data=0x00.
7. Reset mid-operation:
   - Assert rst asynchronously with Level=3 and Overflow=1.
   - All outputs return to reset values immediately, without waiting for a CLK edge.
